// File: rtl/cache_ctrl_fsm_pkg.sv
// Shared types and address-field constants for the direct-mapped write-back cache controller.
// The CACHE_STATS_EN build option is consumed by cache_ctrl_fsm, not by this package.
package cache_ctrl_fsm_pkg;

   localparam int TAG_LSB   = 14;
   localparam int INDEX_LSB = 4;
   localparam int WORD_LSB  = 2;
   localparam int TAG_W     = 18;
   localparam int INDEX_W   = 10;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] data;
      logic        rw;
      logic        valid;
   } cpu_req_t;

   typedef struct packed {
      logic [31:0] data;
      logic        ready;
   } cpu_resp_t;

   typedef struct packed {
      logic [31:0]  addr;
      logic [127:0] data;
      logic         rw;
      logic         valid;
   } mem_req_t;

   typedef struct packed {
      logic [127:0] data;
      logic         ready;
   } mem_resp_t;

   typedef struct packed {
      logic             valid;
      logic             dirty;
      logic [TAG_W-1:0] tag;
   } cache_tag_t;

   typedef struct packed {
      logic [INDEX_W-1:0] index;
      logic               we;
   } cache_req_t;

   typedef logic [127:0] cache_data_t;

   typedef enum logic [2:0] {
      INIT,
      IDLE,
      COMPARE,
      WRITE_BACK,
      ALLOCATE
   } cache_state_t;

   function automatic logic [TAG_W-1:0] addr_tag(input logic [31:0] addr);
      return addr[TAG_LSB +: TAG_W];
   endfunction

   function automatic logic [INDEX_W-1:0] addr_index(input logic [31:0] addr);
      return addr[INDEX_LSB +: INDEX_W];
   endfunction

   function automatic logic [1:0] addr_word(input logic [31:0] addr);
      return addr[WORD_LSB +: 2];
   endfunction

endpackage

// File: rtl/cache_ctrl_fsm_word_sel.sv
// Combinational 32-bit word extract from a cache line, and the line with one word replaced.
module cache_word_sel
   import cache_ctrl_fsm_pkg::*;
(
   input  cache_data_t line,
   input  logic [1:0]  word,
   input  logic [31:0] wdata,
   output logic [31:0] rd_word,
   output cache_data_t merged
);

   logic [6:0] bit_lsb;

   assign bit_lsb = {word, 5'b0};

   always_comb begin
      rd_word                 = line[bit_lsb +: 32];
      merged                  = line;
      merged[bit_lsb +: 32]   = wdata;
   end

endmodule

// File: rtl/cache_ctrl_fsm.sv
// Direct-mapped write-back/write-allocate cache controller: tag-array sweep, lookup, victim write-back, refill.
// Define CACHE_STATS_EN to add the hit_count / miss_count / wb_count statistics ports.
module cache_ctrl_fsm
   import cache_ctrl_fsm_pkg::*;
#(
   parameter int NUM_LINES = 1024
`ifdef CACHE_STATS_EN
   ,parameter int STAT_W   = 32
`endif
)(
   input  logic        clk,
   input  logic        rst_n,
   input  cpu_req_t    cpu_req,
   output cpu_resp_t   cpu_res,
   output mem_req_t    mem_req,
   input  mem_resp_t   mem_data,
   output cache_req_t  tag_req,
   output cache_tag_t  tag_write,
   input  cache_tag_t  tag_read,
   output cache_req_t  data_req,
   output cache_data_t data_write,
   input  cache_data_t data_read
`ifdef CACHE_STATS_EN
   ,output logic [STAT_W-1:0] hit_count,
   output logic [STAT_W-1:0] miss_count,
   output logic [STAT_W-1:0] wb_count
`endif
);

   localparam logic [INDEX_W-1:0] LAST_IDX = INDEX_W'(NUM_LINES - 1);

   cache_state_t       state, next_state;
   logic [INDEX_W-1:0] cnt;
   cpu_req_t           req_q;
   logic [TAG_W-1:0]   req_tag;
   logic [INDEX_W-1:0] req_index;
   logic               hit;
   logic [31:0]        rd_word;
   cache_data_t        merged_line;
   logic               unused_req_bits;

   assign req_tag         = addr_tag(req_q.addr);
   assign req_index       = addr_index(req_q.addr);
   assign hit             = tag_read.valid && (tag_read.tag == req_tag);
   assign unused_req_bits = ^{req_q.addr[1:0], req_q.valid};

   cache_word_sel u_word_sel (
      .line    (data_read),
      .word    (addr_word(req_q.addr)),
      .wdata   (req_q.data),
      .rd_word (rd_word),
      .merged  (merged_line)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= INIT;
         cnt   <= '0;
      end else begin
         state <= next_state;
         if (state == INIT) cnt <= cnt + 1'b1;
      end
   end

   // Request data is only meaningful after capture, so it carries no reset.
   always_ff @(posedge clk) begin
      if (state == IDLE && cpu_req.valid) req_q <= cpu_req;
   end

   always_comb begin
      next_state     = state;
      cpu_res        = '0;
      mem_req        = '0;
      tag_req.index  = req_index;
      tag_req.we     = 1'b0;
      data_req.index = req_index;
      data_req.we    = 1'b0;
      tag_write      = '0;
      data_write     = '0;

      case (state)
         INIT: begin
            tag_req.index = cnt;
            tag_req.we    = 1'b1;
            if (cnt == LAST_IDX) next_state = IDLE;
         end
         IDLE: begin
            if (cpu_req.valid) next_state = COMPARE;
         end
         COMPARE: begin
            if (hit) begin
               cpu_res.ready = 1'b1;
               next_state    = IDLE;
               if (req_q.rw) begin
                  data_write  = merged_line;
                  tag_write   = {1'b1, 1'b1, req_tag};
                  tag_req.we  = 1'b1;
                  data_req.we = 1'b1;
               end else begin
                  cpu_res.data = rd_word;
               end
            end else if (tag_read.valid && tag_read.dirty) begin
               next_state = WRITE_BACK;
            end else begin
               next_state = ALLOCATE;
            end
         end
         WRITE_BACK: begin
            mem_req.addr  = {tag_read.tag, req_index, 4'h0};
            mem_req.data  = data_read;
            mem_req.rw    = 1'b1;
            mem_req.valid = 1'b1;
            if (mem_data.ready) next_state = ALLOCATE;
         end
         ALLOCATE: begin
            mem_req.addr  = {req_tag, req_index, 4'h0};
            mem_req.valid = 1'b1;
            // Line and tag land together; the following COMPARE then hits.
            if (mem_data.ready) begin
               data_write  = mem_data.data;
               tag_write   = {1'b1, 1'b0, req_tag};
               tag_req.we  = 1'b1;
               data_req.we = 1'b1;
               next_state  = COMPARE;
            end
         end
         default: next_state = INIT;
      endcase
   end

`ifdef CACHE_STATS_EN
   logic refill_q;
   logic hit_ev, miss_ev, wb_ev;

   assign hit_ev  = (state == COMPARE) && hit && !refill_q;
   assign miss_ev = (state == COMPARE) && !hit;
   assign wb_ev   = (state == COMPARE) && (next_state == WRITE_BACK);

   // refill_q marks the COMPARE that follows a refill so its hit is not counted.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         refill_q   <= 1'b0;
         hit_count  <= '0;
         miss_count <= '0;
         wb_count   <= '0;
      end else begin
         if (state == ALLOCATE && mem_data.ready) refill_q <= 1'b1;
         else if (state == COMPARE)              refill_q <= 1'b0;
         if (hit_ev)  hit_count  <= hit_count + 1'b1;
         if (miss_ev) miss_count <= miss_count + 1'b1;
         if (wb_ev)   wb_count   <= wb_count + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_cache_ctrl_fsm.sv
// Directed self-checking bench for cache_ctrl_fsm with behavioural tag/data arrays.
module tb_cache_ctrl_fsm;
   import cache_ctrl_fsm_pkg::*;

   logic        clk;
   logic        rst_n;
   cpu_req_t    cpu_req;
   cpu_resp_t   cpu_res;
   mem_req_t    mem_req;
   mem_resp_t   mem_data;
   cache_req_t  tag_req;
   cache_tag_t  tag_write;
   cache_tag_t  tag_read;
   cache_req_t  data_req;
   cache_data_t data_write;
   cache_data_t data_read;
`ifdef CACHE_STATS_EN
   logic [31:0] hit_count, miss_count, wb_count;
`endif

   cache_tag_t  tag_mem  [1024];
   cache_data_t data_mem [1024];

   int n_checks = 0;
   int n_errors = 0;

   localparam cache_data_t LINE_A   = {32'hA3A3A3A3, 32'hA2A2A2A2, 32'hCAFEF00D, 32'hA0A0A0A0};
   localparam cache_data_t LINE_A_W = {32'hA3A3A3A3, 32'h11223344, 32'hCAFEF00D, 32'hA0A0A0A0};
   localparam cache_data_t LINE_B   = {32'hB3B3B3B3, 32'hB2B2B2B2, 32'hB1B1B1B1, 32'h0BADBEEF};

   cache_ctrl_fsm dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .cpu_req    (cpu_req),
      .cpu_res    (cpu_res),
      .mem_req    (mem_req),
      .mem_data   (mem_data),
      .tag_req    (tag_req),
      .tag_write  (tag_write),
      .tag_read   (tag_read),
      .data_req   (data_req),
      .data_write (data_write),
      .data_read  (data_read)
`ifdef CACHE_STATS_EN
      ,.hit_count (hit_count),
      .miss_count (miss_count),
      .wb_count   (wb_count)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always_comb begin
      tag_read  = tag_mem[tag_req.index];
      data_read = data_mem[data_req.index];
   end

   always @(posedge clk) begin
      if (tag_req.we)  tag_mem[tag_req.index]   <= tag_write;
      if (data_req.we) data_mem[data_req.index] <= data_write;
   end

   task automatic check(input string tag, input logic [161:0] got, input logic [161:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   initial begin
      int n_ok, n_rdy, n_bad;
      mem_req_t wb_exp;

      rst_n    = 1'b0;
      cpu_req  = '0;
      mem_data = '0;
      repeat (3) tick();
      check("rst_ready", cpu_res.ready, 1'b0);
      check("rst_mem_valid", mem_req.valid, 1'b0);
      check("rst_data_we", data_req.we, 1'b0);

      // Release reset with a read of 0x1234 already pending; it must wait out the sweep.
      rst_n   = 1'b1;
      cpu_req = {32'h0000_1234, 32'h0, 1'b0, 1'b1};
      #1;
      n_ok  = 0;
      n_rdy = 0;
      for (int i = 0; i < 1024; i++) begin
         if (tag_req.we && tag_req.index == 10'(i) && tag_write == '0) n_ok++;
         if (cpu_res.ready) n_rdy++;
         tick();
      end
      check("init_writes", n_ok, 1024);
      check("init_no_ready", n_rdy, 0);
      check("idle_tag_we", tag_req.we, 1'b0);
      check("idle_mem_valid", mem_req.valid, 1'b0);

      // Cold read miss -> ALLOCATE
      tick();
      cpu_req.valid = 1'b0;
      #1;
      check("cold_cmp_quiet", {cpu_res.ready, tag_req.we, data_req.we}, 3'b000);
      tick();
      check("alloc_req", mem_req, {32'h0000_1230, 128'h0, 1'b0, 1'b1});
      repeat (3) tick();
      check("alloc_hold", {mem_req, cpu_res.ready}, {32'h0000_1230, 128'h0, 1'b0, 1'b1, 1'b0});
      mem_data = {LINE_A, 1'b1};
      #1;
      check("alloc_fill_we", {tag_req.we, data_req.we, tag_write}, {1'b1, 1'b1, 20'h80000});
      check("alloc_fill_data", data_write, LINE_A);
      tick();
      mem_data = '0;
      #1;
      check("rd_hit_resp", cpu_res, {32'hCAFEF00D, 1'b1});
      check("mem_valid_drop", mem_req.valid, 1'b0);
      tick();

      // Stray memory ready while idle must not move the controller
      mem_data = {128'h0, 1'b1};
      #1;
      tick();
      mem_data = '0;
      #1;
      check("stray_ready", {mem_req.valid, tag_req.we, data_req.we, cpu_res.ready}, 4'b0000);

      // Write hit to word 2
      cpu_req = {32'h0000_1238, 32'h11223344, 1'b1, 1'b1};
      #1;
      check("wr_idle_ready", cpu_res.ready, 1'b0);
      tick();
      cpu_req.valid = 1'b0;
      #1;
      check("wr_hit", {cpu_res.ready, tag_req.we, data_req.we, tag_write}, {1'b1, 1'b1, 1'b1, 20'hC0000});
      check("wr_merge", data_write, LINE_A_W);
      tick();
      check("wr_tag_stored", tag_mem[10'h123], 20'hC0000);
      check("wr_data_stored", data_mem[10'h123], LINE_A_W);

      // Conflict read evicts the dirty line, memory stalls 20 cycles
      cpu_req = {32'h0004_1230, 32'h0, 1'b0, 1'b1};
      tick();
      cpu_req.valid = 1'b0;
      #1;
      check("conf_cmp_quiet", {cpu_res.ready, tag_req.we, data_req.we}, 3'b000);
      tick();
      wb_exp = {32'h0000_1230, LINE_A_W, 1'b1, 1'b1};
      check("wb_req", mem_req, wb_exp);
      n_bad = 0;
      for (int i = 0; i < 20; i++) begin
         if (mem_req !== wb_exp || cpu_res.ready) n_bad++;
         tick();
      end
      check("wb_hold", n_bad, 0);
      mem_data = {128'h0, 1'b1};
      #1;
      tick();
      mem_data = '0;
      #1;
      check("wb_to_alloc", mem_req, {32'h0004_1230, 128'h0, 1'b0, 1'b1});
      mem_data = {LINE_B, 1'b1};
      #1;
      check("alloc2_tag", {tag_req.we, tag_write}, {1'b1, 20'h80010});
      tick();
      mem_data = '0;
      #1;
      check("conf_rd_resp", cpu_res, {32'h0BADBEEF, 1'b1});
      tick();
`ifdef CACHE_STATS_EN
      check("stat_counts", {hit_count, miss_count, wb_count}, {32'd1, 32'd2, 32'd1});
`endif

      // Reset while a refill is outstanding
      cpu_req = {32'h0000_2000, 32'h0, 1'b0, 1'b1};
      tick();
      cpu_req.valid = 1'b0;
      tick();
      check("alloc3_req", {mem_req.valid, mem_req.addr}, {1'b1, 32'h0000_2000});
      rst_n = 1'b0;
      tick();
      check("rst_mid_valid", mem_req.valid, 1'b0);
      check("rst_mid_init", {tag_req.we, tag_req.index}, {1'b1, 10'd0});
      rst_n = 1'b1;
      tick();
      check("init_restart", {tag_req.we, tag_req.index}, {1'b1, 10'd1});
`ifdef CACHE_STATS_EN
      check("stat_reset", {hit_count, miss_count, wb_count}, 96'h0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
